// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the tinyCPU datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic             wb_sel;
    logic             alu_src_imm;
    logic             imm_sel;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, func3, func7, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel,
               alu_src_imm, imm_sel, alu_ctrl, illegal, state, instret
    );

    modport slave (
        output op, func3, func7, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel,
               alu_src_imm, imm_sel, alu_ctrl, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for tinyCPU: R-type, lw, sw,
// trap on anything else, plus a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        C_R   = 2'd0,
        C_LD  = 2'd1,
        C_ST  = 2'd2,
        C_ILL = 2'd3
    } cls_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [3:0]       alu_q, alu_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    cls_t             dec_cls;
    logic [3:0]       dec_alu;
    logic             retire;

    // Instruction classification and ALU op selection from the decoder fields.
    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_ADD;
        case (bus.op)
            OP_R: begin
                if ((bus.func7 == F7_BASE) ||
                    ((bus.func7 == F7_ALT) && ((bus.func3 == 3'b000) || (bus.func3 == 3'b101)))) begin
                    dec_cls = C_R;
                end
            end
            OP_LD:   if (bus.func3 == 3'b010) dec_cls = C_LD;
            OP_ST:   if (bus.func3 == 3'b010) dec_cls = C_ST;
            default: dec_cls = C_ILL;
        endcase
        if (dec_cls == C_R) begin
            case (bus.func3)
                3'b000: dec_alu = bus.func7[5] ? ALU_SUB : ALU_ADD;
                3'b001: dec_alu = ALU_SLL;
                3'b010: dec_alu = ALU_SLT;
                3'b011: dec_alu = ALU_SLTU;
                3'b100: dec_alu = ALU_XOR;
                3'b101: dec_alu = bus.func7[5] ? ALU_SRA : ALU_SRL;
                3'b110: dec_alu = ALU_OR;
                3'b111: dec_alu = ALU_AND;
                default: dec_alu = ALU_ADD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            alu_q     <= ALU_ADD;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic; class and ALU op are captured only in DECODE.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        instret_d = instret_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = dec_cls;
                alu_d   = dec_alu;
                state_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC:   state_d = (cls_q == C_R) ? S_WB : S_MEM;
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (cls_q == C_ST) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        if (retire) instret_d = instret_q + CNT_W'(1);
    end

    // Per-state strobes; everything is held low while reset is asserted.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.ir_we       = 1'b0;
        bus.pc_we       = 1'b0;
        bus.reg_we      = 1'b0;
        bus.wb_sel      = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.imm_sel     = 1'b0;
        bus.illegal     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_we   = bus.mem_ready;
                    bus.pc_we   = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.alu_src_imm = (cls_q != C_R);
                    bus.imm_sel     = (cls_q == C_ST);
                end
                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.mem_we   = (cls_q == C_ST);
                end
                S_WB: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = (cls_q == C_LD);
                end
                S_TRAP:  bus.illegal = 1'b1;
                default: bus.illegal = 1'b0;
            endcase
        end
    end

    assign bus.alu_ctrl = alu_q;
    assign bus.state    = state_q;
    assign bus.instret  = instret_q;

endmodule
